// File: rtl/param_bankgroup_pkg.sv
// Shared definitions for the parametrised two-bank bank group.
// Holds the parameter defaults, the memory-map base and the word-to-bank split.
package param_bankgroup_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_FIFO_DEPTH = 128;

    typedef enum logic {
        PAT_RANDOM = 1'b0,
        PAT_FIFO   = 1'b1
    } pattern_e;

    typedef struct packed {
        logic [30:0] row;
        logic        bank;
    } bank_loc_t;

    function automatic int random_base(input int num_ch, input int depth);
        return num_ch * depth;
    endfunction

    // Even words go to bank 0, odd words to bank 1; the remaining bits form the row.
    function automatic bank_loc_t split_word(input logic [31:0] word);
        bank_loc_t loc;
        loc.bank = word[0];
        loc.row  = word[31:1];
        return loc;
    endfunction

endpackage

// File: rtl/bg_fifo_ptr.sv
// Pointer/occupancy tracker for one FIFO channel of the bank group.
// push/pop arrive pre-qualified (never push when full, never pop when empty).
module bg_fifo_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH):0]       wr_ptr,
    output logic [$clog2(DEPTH):0]       rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Index wraps at DEPTH-1 (not necessarily a power of two); MSB is the wrap bit.
    function automatic logic [PW:0] bump(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(DEPTH - 1)) return {~p[PW], {PW{1'b0}}};
        return {p[PW], p[PW-1:0] + PW'(1)};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM bank: one read or one write per cycle,
// read data registered and held until the next read.
module single_port_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/param_bankgroup.sv
// Two interleaved single-port banks holding NUM_CH FIFO regions plus a random-access
// region above them; arbitrates FIFO/random accesses onto the banks with 1-cycle reads.
module param_bankgroup
    import param_bankgroup_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               pattern,
    input  logic [CH_W-1:0]                    ch_sel,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [DATA_W-1:0]                  din,
    input  logic                               we,
    input  logic                               re,
    input  logic                               flush,
    output logic                               wr_ack,
    output logic                               rd_ack,
    output logic [DATA_W-1:0]                  dout,
    output logic                               dout_valid,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_W       = ADDR_W - 1;
    localparam int RANDOM_BASE = random_base(NUM_CH, FIFO_DEPTH);
    localparam int STAGES      = 1;

    logic [NUM_CH-1:0][PW:0]      ch_wr_ptr, ch_rd_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0] ch_count;
    logic [NUM_CH-1:0]            ch_full, ch_empty;

    logic              ch_ok, fifo_mode, acc_ok, same_bank, rnd_ok;
    logic [CH_W-1:0]   sel;
    logic              fifo_wr, fifo_rd, rnd_wr, rnd_rd;
    logic [31:0]       ch_base, fifo_wr_word, fifo_rd_word, rnd_word, wr_word, rd_word;
    bank_loc_t         wr_loc, rd_loc;
    logic [1:0][DATA_W-1:0] bank_q;
    logic              rd_bank_q;
    logic [STAGES:0]   vld_pipe;

    // Out-of-range channel selects see an empty, untouchable channel.
    assign ch_ok     = (int'(ch_sel) < NUM_CH);
    assign sel       = ch_ok ? ch_sel : '0;
    assign fifo_mode = (pattern_e'(pattern) == PAT_FIFO);
    assign acc_ok    = rst & en & ~flush;

    assign full  = ch_ok & ch_full[sel];
    assign empty = ~ch_ok | ch_empty[sel];
    assign count = ch_ok ? ch_count[sel] : '0;

    assign ch_base      = 32'(sel) * 32'(FIFO_DEPTH);
    assign fifo_wr_word = ch_base + 32'(ch_wr_ptr[sel][PW-1:0]);
    assign fifo_rd_word = ch_base + 32'(ch_rd_ptr[sel][PW-1:0]);
    assign rnd_word     = 32'(addr) + 32'(RANDOM_BASE);
    assign rnd_ok       = (rnd_word < (32'd1 << ADDR_W));

    // FIFO_DEPTH is even, so the pointer LSB is the bank of the entry.
    assign same_bank = (ch_wr_ptr[sel][0] == ch_rd_ptr[sel][0]);

    // Reads win a same-bank collision; the write is simply refused and retried by the source.
    assign fifo_rd = acc_ok & fifo_mode & ch_ok & re & ~ch_empty[sel];
    assign fifo_wr = acc_ok & fifo_mode & ch_ok & we & ~ch_full[sel] & ~(fifo_rd & same_bank);
    assign rnd_wr  = acc_ok & ~fifo_mode & rnd_ok & we;
    assign rnd_rd  = acc_ok & ~fifo_mode & rnd_ok & re & ~we;

    assign wr_ack = fifo_wr | rnd_wr;
    assign rd_ack = fifo_rd | rnd_rd;

    assign wr_word = fifo_mode ? fifo_wr_word : rnd_word;
    assign rd_word = fifo_mode ? fifo_rd_word : rnd_word;
    assign wr_loc  = split_word(wr_word);
    assign rd_loc  = split_word(rd_word);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bg_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_ptr (
            .clk    (clk),
            .rst    (rst),
            .push   (fifo_wr && (sel == CH_W'(c))),
            .pop    (fifo_rd && (sel == CH_W'(c))),
            .clear  (en & flush),
            .wr_ptr (ch_wr_ptr[c]),
            .rd_ptr (ch_rd_ptr[c]),
            .count  (ch_count[c]),
            .full   (ch_full[c]),
            .empty  (ch_empty[c])
        );
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic             b_en, b_we;
        logic [ROW_W-1:0] b_addr;

        always_comb begin
            b_en   = 1'b0;
            b_we   = 1'b0;
            b_addr = '0;
            if (wr_ack && (wr_loc.bank == 1'(b))) begin
                b_en   = 1'b1;
                b_we   = 1'b1;
                b_addr = wr_loc.row[ROW_W-1:0];
            end else if (rd_ack && (rd_loc.bank == 1'(b))) begin
                b_en   = 1'b1;
                b_addr = rd_loc.row[ROW_W-1:0];
            end
        end

        single_port_ram #(.DATA_W(DATA_W), .ADDR_W(ROW_W)) u_ram (
            .clk  (clk),
            .en   (b_en),
            .we   (b_we),
            .addr (b_addr),
            .din  (din),
            .dout (bank_q[b])
        );
    end

    assign vld_pipe[0] = rd_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[STAGES:1] <= '0;
            rd_bank_q          <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (rd_ack) rd_bank_q <= rd_loc.bank;
        end
    end

    // Bank output holds stale data between reads, so it is masked whenever not valid.
    assign dout_valid = vld_pipe[STAGES];
    assign dout       = dout_valid ? bank_q[rd_bank_q] : '0;

    logic unused_ok;
    assign unused_ok = ^{wr_loc.row[30:ROW_W], rd_loc.row[30:ROW_W], ch_wr_ptr, ch_rd_ptr};

endmodule
